// File: rtl/cnn_layer_accel_job_sched_if.sv
// Host descriptor and quad job handshake bundle for the layer job scheduler.
// master drives the requests (host/quad side), slave is the scheduler.
interface cnn_layer_accel_job_sched_if;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_data;
  logic         job_start;
  logic         job_accept;
  logic [127:0] job_parameters;
  logic         job_fetch_request;
  logic         job_fetch_ack;
  logic         job_fetch_complete;
  logic         job_complete;
  logic         job_complete_ack;

  modport master (
    output desc_valid, desc_data,
    output job_accept, job_fetch_request,
    output job_fetch_complete, job_complete,
    input  desc_ready, job_start, job_parameters,
    input  job_fetch_ack, job_complete_ack
  );

  modport slave (
    input  desc_valid, desc_data,
    input  job_accept, job_fetch_request,
    input  job_fetch_complete, job_complete,
    output desc_ready, job_start, job_parameters,
    output job_fetch_ack, job_complete_ack
  );
endinterface

// File: rtl/cnn_layer_accel_job_sched.sv
// Job scheduler: descriptor FIFO feeding a START/FETCH/RUN/ACK handshake
// sequencer toward one quad, with per-state watchdog and done counter.
module cnn_layer_accel_job_sched #(
  parameter int C_FIFO_DEPTH = 4,
  parameter int C_TIMEOUT    = 4095
) (
  input  logic        clk_if,
  input  logic        rst_n,
  cnn_layer_accel_job_sched_if.slave bus,
  output logic        busy,
  output logic [15:0] done_count,
  output logic        timeout_err,
  input  logic        err_clr
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int WW = $clog2(C_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;

  logic [127:0]  mem [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          ready_q;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [WW-1:0] wd;
  logic          tmo;
  logic          push;
  logic          pop;
  logic          ack_q;
  logic          acked;
  logic          done_inc;
  logic [15:0]   done_q;
  logic          err_q;

  assign push = bus.desc_valid & ready_q;
  assign tmo  = (state != S_IDLE) && (wd == WW'(C_TIMEOUT - 1));
  // A stuck START is dropped on timeout rather than retried.
  assign pop  = (state == S_START) && (bus.job_accept || tmo);

  assign count_nxt = count + {{AW{1'b0}}, push}
                           - {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    done_inc  = 1'b0;
    if (tmo) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (1'b1)
        state == S_IDLE:
          if (count != '0) state_nxt = S_START;
        state == S_START:
          if (bus.job_accept) state_nxt = S_FETCH;
        state == S_FETCH:
          if (bus.job_fetch_complete && (acked || ack_q))
            state_nxt = S_RUN;
        state == S_RUN:
          if (bus.job_complete) state_nxt = S_ACK;
        state == S_ACK:
          if (!bus.job_complete) begin
            state_nxt = S_IDLE;
            done_inc  = 1'b1;
          end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wd      <= '0;
      ack_q   <= 1'b0;
      acked   <= 1'b0;
      count   <= '0;
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state_nxt == S_IDLE)
        wd <= '0;
      else
        wd <= wd + 1'b1;
      // One grant per job: blocked while pulsing and once pulsed.
      ack_q <= (state == S_FETCH) && bus.job_fetch_request
               && !acked && !ack_q && !tmo;
      acked <= (state == S_FETCH) && (acked || ack_q);
      count   <= count_nxt;
      ready_q <= (count_nxt != (AW+1)'(C_FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      done_q <= done_q + {15'd0, done_inc};
      if (tmo)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_if) begin
    if (push) mem[wr_ptr] <= bus.desc_data;
  end

  assign bus.desc_ready       = ready_q;
  assign bus.job_start        = (state == S_START);
  assign bus.job_parameters   = (state == S_START) ? mem[rd_ptr] : '0;
  assign bus.job_fetch_ack    = ack_q;
  assign bus.job_complete_ack = (state == S_ACK);

  assign busy        = (state != S_IDLE) || (count != '0);
  assign done_count  = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_sched.sv
// Randomized bench for the job scheduler: host/quad drivers plus a
// queue-based reference model of descriptor order, occupancy and done count.
module tb_cnn_layer_accel_job_sched;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic [15:0] done_count;

  cnn_layer_accel_job_sched_if bus ();

  cnn_layer_accel_job_sched #(
    .C_FIFO_DEPTH(DEPTH),
    .C_TIMEOUT(TMO)
  ) dut (
    .clk_if(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .busy(busy),
    .done_count(done_count),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_done = '0;
  int           occ = 0;
  bit           pend_push = 0;
  bit           prev_start = 0;
  bit           prev_rstn = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Occupancy model: pushes seen on the bus, pops seen as job_start falling.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      pend_push = 0;
      prev_start = 0;
      prev_rstn = 0;
    end else begin
      if (pend_push) occ++;
      if (prev_start && !bus.job_start) occ--;
      if (prev_rstn) check("desc_ready_occ", bus.desc_ready, occ < DEPTH);
      pend_push = bus.desc_valid && bus.desc_ready;
      prev_start = bus.job_start;
      prev_rstn = 1;
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    bit took = 0;
    bus.desc_valid = 1'b1;
    bus.desc_data = d;
    for (int i = 0; i < 300 && !took; i++) begin
      took = bus.desc_ready;
      tick();
    end
    bus.desc_valid = 1'b0;
    if (took) exp_q.push_back(d);
    else check("push_timeout", 0, 1);
  endtask

  task automatic wait_start(output bit seen);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (bus.job_start) seen = 1;
      else tick();
    end
    if (!seen) check("start_wait", 0, 1);
  endtask

  task automatic check_head;
    if (exp_q.size() == 0) check("exp_q_empty", 0, 1);
    else check("job_parameters", bus.job_parameters, exp_q.pop_front());
  endtask

  task automatic accept_and_fetch(input int acc_dly, input bit glitch);
    int acks = 0;
    repeat (acc_dly) tick();
    check("start_held", bus.job_start, 1);
    bus.job_accept = 1'b1;
    tick();
    bus.job_accept = 1'b0;
    check("start_drop", bus.job_start, 0);
    if (glitch) begin
      bus.job_fetch_complete = 1'b1;
      tick();
      bus.job_fetch_complete = 1'b0;
      bus.job_complete = 1'b1;
      tick();
      check("early_fc_ignored", bus.job_complete_ack, 0);
      bus.job_complete = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick();
    bus.job_fetch_request = 1'b1;
    tick();
    check("fetch_ack_next", bus.job_fetch_ack, 1);
    acks += int'(bus.job_fetch_ack);
    repeat (2) begin
      tick();
      acks += int'(bus.job_fetch_ack);
    end
    bus.job_fetch_request = 1'b0;
    repeat (2) begin
      tick();
      acks += int'(bus.job_fetch_ack);
    end
    check("fetch_ack_cnt", acks, 1);
    bus.job_fetch_complete = 1'b1;
    tick();
    bus.job_fetch_complete = 1'b0;
  endtask

  task automatic serve(input int acc_dly, input bit glitch);
    bit seen;
    wait_start(seen);
    if (!seen) return;
    check_head();
    accept_and_fetch(acc_dly, glitch);
    repeat ($urandom_range(0, 4)) tick();
    bus.job_complete = 1'b1;
    tick();
    check("complete_ack_on", bus.job_complete_ack, 1);
    repeat ($urandom_range(0, 3)) tick();
    bus.job_complete = 1'b0;
    tick();
    check("complete_ack_off", bus.job_complete_ack, 0);
    exp_done++;
    check("done_count", done_count, exp_done);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    bit any;
    int n;
    bus.desc_valid = 0;
    bus.desc_data = '0;
    bus.job_accept = 0;
    bus.job_fetch_request = 0;
    bus.job_fetch_complete = 0;
    bus.job_complete = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_desc_ready", bus.desc_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_job_start", bus.job_start, 0);
    check("rst_done", done_count, 0);
    check("rst_err", timeout_err, 0);
    rst_n = 1'b1;
    check("ready_pre_clk", bus.desc_ready, 0);
    tick();
    check("ready_first_clk", bus.desc_ready, 1);

    // Single job with a three-cycle accept delay.
    push({16{8'hA5}});
    serve(3, 0);
    check("single_busy", busy, 0);

    // Five back-to-back pushes into a depth-4 queue.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          push(rnd128());
          if (i == 3) check("full_after_4", bus.desc_ready, 0);
        end
      end
      begin
        for (int i = 0; i < 5; i++) serve(3, 0);
      end
    join
    check("five_done", done_count, 6);

    // Randomized traffic with occasional early fetch_complete glitches.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 4)) tick();
          push(rnd128());
        end
      end
      begin
        for (int i = 0; i < 40; i++)
          serve($urandom_range(0, 5), $urandom_range(0, 3) == 0);
      end
    join
    check("rand_idle_busy", busy, 0);

    // Watchdog in START: accept never comes.
    push(rnd128());
    push(rnd128());
    wait_start(seen);
    check_head();
    n = 0;
    while (bus.job_start && n < 40) begin
      n++;
      tick();
    end
    check("tmo_start_cycles", n, TMO);
    check("tmo_err_set", timeout_err, 1);
    serve(1, 0);
    check("tmo_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_err_clr", timeout_err, 0);

    // Reset while RUN with two jobs still queued.
    push(rnd128());
    push(rnd128());
    push(rnd128());
    wait_start(seen);
    check_head();
    accept_and_fetch(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_job_start", bus.job_start, 0);
    check("arst_fetch_ack", bus.job_fetch_ack, 0);
    check("arst_cmpl_ack", bus.job_complete_ack, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done_count, 0);
    check("arst_err", timeout_err, 0);
    check("arst_ready", bus.desc_ready, 0);
    exp_q.delete();
    exp_done = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    any = 0;
    repeat (20) begin
      tick();
      any |= bus.job_start | busy;
    end
    check("post_rst_quiet", any, 0);
    check("post_rst_ready", bus.desc_ready, 1);

    // Counter wrap.
    force dut.done_q = 16'hFFFF;
    tick();
    release dut.done_q;
    exp_done = 16'hFFFF;
    check("done_preload", done_count, 16'hFFFF);
    push(rnd128());
    serve(2, 0);
    check("done_wrapped", done_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
